// File: rtl/gfx256_wbm_readwrite.sv
// gfx256_wbm_readwrite
// Wishbone B3 classic single-beat bus master that sits behind the read/write
// arbiter. It takes one request at a time, runs a single bus cycle and returns
// a one-cycle ack_o (with read data on reads). A watchdog aborts cycles that
// the slave never answers, so a hung slave cannot stall the accelerator.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   read_request_i          read request from arbiter
//   write_request_i, we_i   write request / write enable from arbiter
//   addr_i, sel_i, dat_i    byte address, byte selects, write data
//   dat_o                   read data back to arbiter
//   ack_o, err_o            completion pulse; err_o marks slave error/timeout
//   busy_o                  cycle in progress (ACTIVE or DONE)
//   timeout_o               sticky watchdog abort flag, cleared by reset only
//   wbm_*                   Wishbone master side (classic, cti/bte fixed 0)
module gfx256_wbm_readwrite #(
  parameter int WID     = 256,
  parameter int TIMEOUT = 1024,
  parameter int TCW     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             read_request_i,
  input  logic             write_request_i,
  input  logic [31:0]      addr_i,
  input  logic             we_i,
  input  logic [WID/8-1:0] sel_i,
  input  logic [WID-1:0]   dat_i,
  output logic [WID-1:0]   dat_o,
  output logic             ack_o,
  output logic             err_o,
  output logic             busy_o,
  output logic             timeout_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic [2:0]       wbm_cti_o,
  output logic [1:0]       wbm_bte_o,
  output logic             wbm_we_o,
  output logic [31:0]      wbm_adr_o,
  output logic [WID/8-1:0] wbm_sel_o,
  output logic [WID-1:0]   wbm_dat_o,
  input  logic [WID-1:0]   wbm_dat_i,
  input  logic             wbm_ack_i,
  input  logic             wbm_err_i
);

  localparam int NB     = WID / 8;
  localparam int AW_LSB = $clog2(NB);
  // Clears the byte-within-beat address bits so the bus sees beat-aligned addresses.
  localparam logic [31:0] ADR_MASK = ~((32'd1 << AW_LSB) - 32'd1);
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [TCW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  state_t           r_state, w_state;
  logic             r_cyc, w_cyc;
  logic             r_we, w_we;
  logic             r_ack, w_ack;
  logic             r_err, w_err;
  logic             r_busy, w_busy;
  logic             r_to, w_to;
  logic [31:0]      r_adr, w_adr;
  logic [NB-1:0]    r_sel, w_sel;
  logic [WID-1:0]   r_wdat, w_wdat;
  logic [WID-1:0]   r_rdat, w_rdat;
  logic [TCW-1:0]   r_cnt, w_cnt;

  // Watchdog counter holds at all-ones instead of wrapping back to zero.
  function automatic logic [TCW-1:0] sat_inc(input logic [TCW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    w_state = r_state;
    w_cyc   = r_cyc;
    w_we    = r_we;
    w_ack   = 1'b0;
    w_err   = 1'b0;
    w_to    = r_to;
    w_adr   = r_adr;
    w_sel   = r_sel;
    w_wdat  = r_wdat;
    w_rdat  = r_rdat;
    w_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (write_request_i || read_request_i) begin
          w_adr   = addr_i & ADR_MASK;
          w_sel   = sel_i;
          w_wdat  = dat_i;
          // A write request takes priority if both are raised together.
          w_we    = write_request_i & we_i;
          w_cyc   = 1'b1;
          w_cnt   = '0;
          w_state = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (wbm_ack_i) begin
          w_cyc   = 1'b0;
          w_ack   = 1'b1;
          if (!r_we) w_rdat = wbm_dat_i;
          w_state = S_DONE;
        end else if (wbm_err_i) begin
          w_cyc   = 1'b0;
          w_ack   = 1'b1;
          w_err   = 1'b1;
          w_state = S_DONE;
        end else if (TO_EN && (r_cnt == TO_LAST)) begin
          w_cyc   = 1'b0;
          w_ack   = 1'b1;
          w_err   = 1'b1;
          w_to    = 1'b1;
          w_state = S_DONE;
        end else begin
          w_cnt   = sat_inc(r_cnt);
        end
      end
      // Requester is still dropping its request this cycle, so ignore it.
      S_DONE: w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_to    <= 1'b0;
      r_adr   <= '0;
      r_sel   <= '0;
      r_wdat  <= '0;
      r_rdat  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_cyc   <= w_cyc;
      r_we    <= w_we;
      r_ack   <= w_ack;
      r_err   <= w_err;
      r_busy  <= w_busy;
      r_to    <= w_to;
      r_adr   <= w_adr;
      r_sel   <= w_sel;
      r_wdat  <= w_wdat;
      r_rdat  <= w_rdat;
      r_cnt   <= w_cnt;
    end
  end

  assign dat_o     = r_rdat;
  assign ack_o     = r_ack;
  assign err_o     = r_err;
  assign busy_o    = r_busy;
  assign timeout_o = r_to;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_cti_o = 3'b000;
  assign wbm_bte_o = 2'b00;
  assign wbm_we_o  = r_we;
  assign wbm_adr_o = r_adr;
  assign wbm_sel_o = r_sel;
  assign wbm_dat_o = r_wdat;

endmodule

// File: doc/gfx256_wbm_readwrite.md
Name: gfx256_wbm_readwrite

Overview:
- Wishbone B3 classic single-beat bus master directly downstream of the read/write arbiter.
- Accepts one arbitrated request at a time (read or write, 256-bit, byte-selected).
- Runs the bus cycle and returns a one-cycle ack to the arbiter, plus read data on reads.
- Adds a bus-timeout watchdog and error reporting so a hung slave cannot stall the accelerator.

Parameters:
- WID, 256, data width in bits; byte lanes = WID/8; AW_LSB = log2(WID/8) (5 for 256).
- TIMEOUT, 1024, cycles in ACTIVE before abort; 0 disables the watchdog.
- TCW, 16, timeout counter width; must satisfy TIMEOUT < 2^TCW.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- read_request_i  in  1  read request from arbiter
- write_request_i  in  1  write request from arbiter
- addr_i  in  32  byte address
- we_i  in  1  write enable from arbiter (meaningful with write_request_i)
- sel_i  in  WID/8  byte selects
- dat_i  in  WID  write data from arbiter
- dat_o  out  WID  read data to arbiter
- ack_o  out  1  one-cycle completion pulse to arbiter
- err_o  out  1  high with ack_o when the cycle ended by wbm_err_i or timeout
- busy_o  out  1  high in ACTIVE and DONE
- timeout_o  out  1  sticky, set on any watchdog abort, cleared only by reset
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_cti_o  out  3  constant 3'b000 (classic)
- wbm_bte_o  out  2  constant 2'b00
- wbm_we_o  out  1  Wishbone write enable
- wbm_adr_o  out  32  Wishbone address, low AW_LSB bits forced 0
- wbm_sel_o  out  WID/8  byte selects
- wbm_dat_o  out  WID  write data
- wbm_dat_i  in  WID  read data
- wbm_ack_i  in  1  slave ack
- wbm_err_i  in  1  slave error

Behaviour:
- All outputs are registered.
- Reset values: cyc/stb/we/ack_o/err_o/busy_o/timeout_o = 0; adr/sel/dat_o/wbm_dat_o = 0; state IDLE; counter 0.
- States: IDLE, ACTIVE, DONE.
- IDLE:
  - If write_request_i | read_request_i at a rising edge, capture the request: adr = {addr_i[31:AW_LSB], 0}, sel = sel_i, wbm_dat_o = dat_i.
  - wbm_we_o = write_request_i & we_i.
  - Assert cyc/stb; go to ACTIVE; clear counter.
  - If both requests are high, write wins (arbiter guarantees one-hot; no error raised).
- ACTIVE:
  - cyc/stb/adr/sel/we/wbm_dat_o held stable; the request inputs are ignored.
  - On wbm_ack_i:
    - Deassert cyc/stb at the next edge.
    - On reads, dat_o <= wbm_dat_i; on writes, dat_o is unchanged.
    - ack_o = 1 for exactly one cycle; go to DONE.
  - On wbm_err_i (ack wins if both are high): same as ack, but dat_o is unchanged and err_o = 1 together with ack_o.
  - Watchdog: if TIMEOUT != 0 and the counter reaches TIMEOUT-1 with no ack/err, abort as for err and set timeout_o.
- DONE:
  - One cycle; ack_o returns to 0.
  - Requests are ignored, because the requester deasserts on the cycle after it sees ack.
  - Then go to IDLE.
- Latency:
  - Request sampled at edge E0; cyc at E0+.
  - Slave ack sampled at edge En gives ack_o and cyc low after En.
  - The next request is accepted no earlier than En+2 (minimum 3 edges per transaction with a zero-wait slave).
- Request dropped during ACTIVE: the bus cycle completes normally and ack_o still pulses.
- Reset mid-cycle: cyc/stb drop asynchronously and the state returns to IDLE; no ack_o is produced.
- Counter saturates and never wraps.
- busy_o = state != IDLE.

Test Plan:
- Read: read_request_i=1, addr_i=0x0000_1234, sel_i=all 1s; slave acks 2 cycles after stb with wbm_dat_i=0xA5...A5 -> wbm_adr_o=0x0000_1220, wbm_we_o=0, single ack_o pulse, dat_o=0xA5...A5, cyc low the same cycle as ack_o.
- Write: write_request_i=1, we_i=1, sel_i=0x0000_00FF, dat_i=0x11..; zero-wait slave -> wbm_we_o=1, wbm_sel_o=0x0000_00FF, wbm_dat_o=dat_i, ack_o pulses once, dat_o unchanged.
- Back-to-back: request held high through ack and for one extra cycle, then re-raised -> exactly one bus cycle per request; DONE gap observed; second cycle starts no earlier than 2 edges after the first ack_o.
- Slave error: wbm_err_i=1 on the 3rd ACTIVE cycle -> ack_o=1 and err_o=1 in the same cycle; dat_o unchanged; timeout_o stays 0.
- Watchdog: TIMEOUT=8, slave never responds -> cyc drops after 8 ACTIVE cycles; ack_o=err_o=1 for one cycle; timeout_o=1 until rst_i.
- Reset mid-cycle: assert rst_i asynchronously in ACTIVE -> cyc/stb/ack_o go to 0 immediately; after release, a new read completes normally.
